// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Operation encoding follows the EX-stage decode; states cover the IDLE->ITER->FIXUP->DONE flow.
// Helper functions classify ops so the top and bench agree on signedness and path.
package mdu_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } mdu_state_t;

  // Two's-complement ops take magnitudes up front and re-apply signs in FIXUP.
  function automatic logic is_signed_op(mdu_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

  function automatic logic is_div_op(mdu_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_muldiv_op(mdu_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between pipeline control (master) and the mul/div unit (slave).
// Request side: start/op/a/b plus flush; result side: busy/done/div_by_zero and HI/LO.
// No queueing: master holds start until busy is low.
interface mul_div_unit_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             start;
  mdu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO, plus MTHI/MTLO writes.
// Latency: accept at cycle 0, done in cycle WIDTH+2 (MDU_FAST_MUL_EN: multiplies done in cycle 1).
// Backpressure: busy high while not IDLE; starts during busy are dropped, flush aborts to IDLE.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  mul_div_unit_if.slave mdu
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;

  mdu_state_t       state;
  logic [CW-1:0]    cnt;
  // Shared shift register: mul = {partial product, multiplier}, div = {remainder, quotient}.
  logic [W2-1:0]    acc;
  // Multiplicand magnitude for mul, divisor magnitude for div.
  logic [WIDTH-1:0] dvsr;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             b_zero;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dbz_q;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [W2-1:0]    iter_nxt;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  // Request qualification and operand magnitudes for signed ops.
  always_comb begin
    accept = mdu.start && !mdu.flush && (state == IDLE);
    a_neg  = is_signed_op(mdu.op) && mdu.a[WIDTH-1];
    b_neg  = is_signed_op(mdu.op) && mdu.b[WIDTH-1];
    a_abs  = a_neg ? (~mdu.a + WIDTH'(1)) : mdu.a;
    b_abs  = b_neg ? (~mdu.b + WIDTH'(1)) : mdu.b;
  end

  // One iteration step: shift-add for mul, restoring shift-subtract for div.
  always_comb begin
    add_sum  = {1'b0, acc[W2-1:WIDTH]} + {1'b0, ({WIDTH{acc[0]}} & dvsr)};
    // Upper W+1 bits of the left-shifted remainder minus the divisor; MSB set means borrow.
    sub_diff = acc[W2-1:WIDTH-1] - {1'b0, dvsr};
    iter_nxt = '0;
    if (is_div) begin
      if (!sub_diff[WIDTH]) begin
        iter_nxt = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        iter_nxt = {acc[W2-2:0], 1'b0};
      end
    end else begin
      iter_nxt = {add_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign fixup of the magnitude result; b==0 forces an all-ones quotient.
  always_comb begin
    prod_fix = neg_q ? (~acc + W2'(1)) : acc;
    q_fix    = neg_q ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
    r_fix    = neg_r ? (~acc[W2-1:WIDTH] + WIDTH'(1)) : acc[W2-1:WIDTH];
    if (is_div) begin
      // With a zero divisor every trial subtract succeeds, leaving |a| as remainder,
      // so the sign-restored remainder is a itself.
      fix_hi = r_fix;
      fix_lo = b_zero ? '1 : q_fix;
    end else begin
      fix_hi = prod_fix[W2-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [W2-1:0] fast_a;
  logic [W2-1:0] fast_b;
  logic [W2-1:0] fast_prod;

  // Single-cycle product; the low 2*WIDTH bits of the extended product are exact for both signednesses.
  always_comb begin
    fast_a    = {{WIDTH{a_neg}}, mdu.a};
    fast_b    = {{WIDTH{b_neg}}, mdu.b};
    fast_prod = fast_a * fast_b;
  end
`endif

  // Control FSM with HI/LO, done and div_by_zero as registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      dvsr   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (mdu.op == MTHI) begin
              hi_q  <= mdu.a;
              dbz_q <= 1'b0;
            end else if (mdu.op == MTLO) begin
              lo_q  <= mdu.a;
              dbz_q <= 1'b0;
            end else if (is_muldiv_op(mdu.op)) begin
              dbz_q <= 1'b0;
`ifdef MDU_FAST_MUL_EN
              if (!is_div_op(mdu.op)) begin
                {hi_q, lo_q} <= fast_prod;
                done_q       <= 1'b1;
                state        <= DONE;
              end else begin
                state <= ITER;
              end
`else
              state <= ITER;
`endif
              is_div <= is_div_op(mdu.op);
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              b_zero <= (mdu.b == '0);
              cnt    <= CW'(WIDTH);
              dvsr   <= is_div_op(mdu.op) ? b_abs : a_abs;
              acc    <= {{WIDTH{1'b0}}, (is_div_op(mdu.op) ? a_abs : b_abs)};
            end
          end
        end
        ITER: begin
          if (mdu.flush) begin
            state <= IDLE;
          end else begin
            acc <= iter_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state <= FIXUP;
            end
          end
        end
        FIXUP: begin
          if (mdu.flush) begin
            state <= IDLE;
          end else begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
            dbz_q  <= is_div && b_zero;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mdu.busy        = (state != IDLE);
  assign mdu.done        = done_q;
  assign mdu.div_by_zero = dbz_q;
  assign mdu.hi          = hi_q;
  assign mdu.lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32: vector table plus flush/reset/busy sequences.
// Cycle k means the period after the k-th rising edge following the accept edge.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mul_div_unit;
  import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif
  localparam int LAT = 34;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mdu   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    mdu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in cycle 1 with start dropped.
  task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
  endtask

  // Walk forward from cycle 'first' until done; cyc=-1 on timeout.
  task automatic wait_done(input int first, output int cyc, output int busy_low);
    cyc      = -1;
    busy_low = 0;
    for (int k = first; k <= first + 100; k++) begin
      if (!bus.busy) busy_low++;
      if (bus.done) begin
        cyc = k;
        break;
      end
      step();
    end
  endtask

  initial begin
    int cyc;
    int busy_low;
    int done_seen;
    int exp_lat;

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = MULT;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;

    vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
    vecs[6]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0};
    vecs[9]  = '{DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[10] = '{MULT,  32'd6,        32'd7,        32'h00000000, 32'd42,       1'b0};
    vecs[11] = '{DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};

    // Reset state
    step();
    step();
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_dbz",  bus.div_by_zero, 0);
    check("reset_hi",   bus.hi, 0);
    check("reset_lo",   bus.lo, 0);
    rst_n = 1'b1;
    step();

    // Vector table
    for (int i = 0; i < 12; i++) begin
      exp_lat = (FAST_MUL && !is_div_op(vecs[i].op)) ? 1 : LAT;
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(1, cyc, busy_low);
      check($sformatf("v%0d_latency", i), cyc, exp_lat);
      check($sformatf("v%0d_busy_low", i), busy_low, 0);
      check($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
      check($sformatf("v%0d_dbz", i), bus.div_by_zero, vecs[i].dbz);
      step();
      check($sformatf("v%0d_idle_after", i), {bus.busy, bus.done}, 2'b00);
    end

    // div_by_zero holds after done and clears on the next accepted start
    check("dbz_hold", bus.div_by_zero, 1);
    issue(MTLO, 32'h0000600D, 32'd0);
    check("dbz_cleared", bus.div_by_zero, 0);
    check("mtlo_lo", bus.lo, 32'h0000600D);
    check("mtlo_no_busy", bus.busy, 0);

    // MTHI, then a DIV flushed in cycle 10
    issue(MTHI, 32'h0000ABCD, 32'd0);
    check("mthi_hi", bus.hi, 32'h0000ABCD);
    check("mthi_no_done", {bus.busy, bus.done}, 2'b00);
    issue(DIV, 32'd100, 32'd7);
    done_seen = 0;
    for (int k = 1; k < 10; k++) begin
      if (bus.done) done_seen++;
      step();
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_busy_c11", bus.busy, 0);
    for (int k = 0; k < 40; k++) begin
      if (bus.done || bus.busy) done_seen++;
      step();
    end
    check("flush_no_done", done_seen, 0);
    check("flush_hi_kept", bus.hi, 32'h0000ABCD);
    check("flush_lo_kept", bus.lo, 32'h0000600D);

    // Start during busy is ignored and not queued
    issue(DIVU, 32'd100, 32'd7);
    step();
    step();
    bus.start = 1'b1;
    bus.op    = MULTU;
    bus.a     = 32'd3;
    bus.b     = 32'd3;
    step();
    step();
    bus.start = 1'b0;
    wait_done(5, cyc, busy_low);
    check("busy_start_latency", cyc, LAT);
    check("busy_start_hi", bus.hi, 32'd2);
    check("busy_start_lo", bus.lo, 32'd14);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.busy || bus.done) done_seen++;
    end
    check("busy_start_not_queued", done_seen, 0);

    // flush together with start in IDLE drops the request
    bus.flush = 1'b1;
    issue(MTHI, 32'h00001234, 32'd0);
    check("flush_start_mthi_hi", bus.hi, 32'd2);
    issue(DIVU, 32'd9, 32'd2);
    bus.flush = 1'b0;
    check("flush_start_div_busy", bus.busy, 0);

    // flush in DONE keeps that cycle's result and pulse
    issue(DIVU, 32'd9, 32'd2);
    wait_done(1, cyc, busy_low);
    bus.flush = 1'b1;
    check("flush_done_pulse", {bus.done, bus.busy}, 2'b11);
    check("flush_done_lo", bus.lo, 32'd4);
    step();
    bus.flush = 1'b0;
    check("flush_done_idle", {bus.busy, bus.done}, 2'b00);
    check("flush_done_hi", bus.hi, 32'd1);

    // Reset in the middle of ITER
    issue(DIV, 32'd100, 32'd7);
    for (int k = 1; k < 5; k++) step();
    check("mid_iter_busy", bus.busy, 1);
    rst_n = 1'b0;
    step();
    check("rst_iter_busy", bus.busy, 0);
    check("rst_iter_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_iter_done", bus.done, 0);
    rst_n = 1'b1;
    step();
    issue(MULTU, 32'd5, 32'd9);
    wait_done(1, cyc, busy_low);
    check("post_rst_lo", bus.lo, 32'd45);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
